freq_meter: RTL and testbench

Equal-precision frequency measurement block for the cymometer. It samples the divided test clock `clk_fx` in the `sys_clk` domain and opens a gate window aligned to `clk_fx` rising edges. Over that window it counts whole `clk_fx` periods and the `sys_clk` cycles they span. Downstream logic computes f_fx = F_sys × fx_count / sys_count and drives the LCD1602 display path.

---
 rtl/freq_meter.sv | 181 ++++++++++++++++++
 tb/tb_freq_meter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Equal-precision frequency meter.
// Opens a gate on a clk_fx rising edge, keeps it open for at least GATE_CYCLES
// sys_clk cycles, then closes it on the next clk_fx rising edge. Reports the
// whole clk_fx periods and the sys_clk cycles spanned between those two edges.
//
// state | meaning
// IDLE  | waiting for start, results held
// ARM   | waiting for the opening clk_fx edge (bounded by TIMEOUT_CYCLES)
// GATE  | minimum gate time running, counting sys_clk cycles and clk_fx edges
// CLOSE | gate time elapsed, waiting for the closing clk_fx edge
module freq_meter #(
    parameter logic [31:0] GATE_CYCLES    = 32'd50_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        clk_fx,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] fx_count,
    output logic [31:0] sys_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATE  = 2'd2,
        ST_CLOSE = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic        sync1_q, sync2_q, prev_q;
    logic        fx_edge;

    logic [31:0] wait_q, wait_d;
    logic [31:0] sys_cnt_q, sys_cnt_d;
    logic [31:0] fx_cnt_q, fx_cnt_d;
    logic [31:0] fx_count_q, fx_count_d;
    logic [31:0] sys_count_q, sys_count_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic [31:0] sys_cnt_inc;
    logic        gate_end;
    logic        wait_end;

    logic        arm_go;
    logic        open_gate;
    logic        gate_close;
    logic        close_ok;
    logic        abort;

    // Two-flop synchronizer for clk_fx plus one history flop for edge detection
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= clk_fx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fx_edge     = sync2_q & ~prev_q;
    assign sys_cnt_inc = sys_cnt_q + 32'd1;
    assign gate_end    = (sys_cnt_inc == GATE_CYCLES);
    assign wait_end    = (wait_q == TIMEOUT_CYCLES - 32'd1);

    // FSM state register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; an edge always wins over an expiring wait
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                state_d = ST_ARM;
            ST_ARM: begin
                if (fx_edge)                    state_d = ST_GATE;
                else if (wait_end)              state_d = ST_IDLE;
            end
            ST_GATE:  if (gate_end)             state_d = ST_CLOSE;
            ST_CLOSE: if (fx_edge || wait_end)  state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and datapath strobes
    always_comb begin
        busy       = (state_q != ST_IDLE);
        arm_go     = (state_q == ST_IDLE) && start;
        open_gate  = (state_q == ST_ARM) && fx_edge;
        gate_close = (state_q == ST_GATE) && gate_end;
        close_ok   = (state_q == ST_CLOSE) && fx_edge;
        abort      = ((state_q == ST_ARM) || (state_q == ST_CLOSE)) && !fx_edge && wait_end;
    end

    // Counter next values: wait timer, gate cycle counter, clk_fx edge counter
    always_comb begin
        wait_d    = wait_q;
        sys_cnt_d = sys_cnt_q;
        fx_cnt_d  = fx_cnt_q;

        if (arm_go || gate_close) begin
            wait_d = 32'd0;
        end else if ((state_q == ST_ARM) || (state_q == ST_CLOSE)) begin
            wait_d = wait_q + 32'd1;
        end

        if (open_gate) begin
            sys_cnt_d = 32'd0;
            fx_cnt_d  = 32'd0;
        end else if (state_q == ST_GATE) begin
            sys_cnt_d = sys_cnt_inc;
            if (fx_edge) begin
                fx_cnt_d = fx_cnt_q + 32'd1;
            end
        end else if (state_q == ST_CLOSE) begin
            sys_cnt_d = sys_cnt_inc;
        end
    end

    // Result next values; the closing edge itself completes the last period
    always_comb begin
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        fx_count_d  = fx_count_q;
        sys_count_d = sys_count_q;

        if (arm_go) begin
            timeout_d = 1'b0;
        end
        if (close_ok) begin
            fx_count_d  = fx_cnt_q + 32'd1;
            sys_count_d = sys_cnt_inc;
            done_d      = 1'b1;
        end else if (abort) begin
            fx_count_d  = 32'd0;
            sys_count_d = 32'd0;
            timeout_d   = 1'b1;
            done_d      = 1'b1;
        end
    end

    // Counter and result registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q      <= 32'd0;
            sys_cnt_q   <= 32'd0;
            fx_cnt_q    <= 32'd0;
            fx_count_q  <= 32'd0;
            sys_count_q <= 32'd0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            sys_cnt_q   <= sys_cnt_d;
            fx_cnt_q    <= fx_cnt_d;
            fx_count_q  <= fx_count_d;
            sys_count_q <= sys_count_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign done      = done_q;
    assign timeout   = timeout_q;
    assign fx_count  = fx_count_q;
    assign sys_count = sys_count_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: stimulus pushes model results, a monitor
// pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int G = 100;
    localparam int T = 50;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        clk_fx  = 1'b0;
    logic        start   = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] fx_count;
    logic [31:0] sys_count;

    typedef struct {
        int fx;
        int sys;
        int to;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int total  = 0;
    int bad    = 0;
    int n_done = 0;

    int fx_half = 150;
    int fx_off  = 0;
    bit fx_run  = 1'b0;

    freq_meter #(
        .GATE_CYCLES    (32'(G)),
        .TIMEOUT_CYCLES (32'(T))
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .clk_fx    (clk_fx),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .fx_count  (fx_count),
        .sys_count (sys_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Test signal generator: 50% duty, period 10*p ns, phase offset fx_off
    initial begin
        forever begin
            wait (fx_run);
            #(fx_off);
            while (fx_run) begin
                clk_fx = 1'b1;
                #(fx_half);
                clk_fx = 1'b0;
                #(fx_half);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: edges arrive every p sys_clk cycles. The gate opens on one,
    // closes on the first edge strictly after G cycles; the measurement aborts
    // if that closing edge is more than T cycles past the gate end, or if
    // there is no signal at all.
    function automatic exp_t model(input int p);
        exp_t e;
        int   n;
        int   s;
        e.fx = 0;
        e.sys = 0;
        e.to = 1;
        if (p > 0) begin
            n = G / p + 1;
            s = n * p;
            if (s - G <= T) begin
                e.fx  = n;
                e.sys = s;
                e.to  = 0;
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge sys_clk) begin
        if (rst_n && done) begin
            n_done++;
            chk("busy_at_done", busy, 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 with nothing pending");
            end else begin
                mon_e = exp_q.pop_front();
                chk("fx_count", fx_count, mon_e.fx);
                chk("sys_count", sys_count, mon_e.sys);
                chk("timeout", timeout, mon_e.to);
            end
        end
    end

    task automatic start_fx(input int p);
        fx_half = 5 * p;
        // offset never a multiple of 5 ns, so no clk_fx transition meets a sys_clk edge
        fx_off  = 5 * $urandom_range(0, 2 * p - 1) + $urandom_range(1, 4);
        fx_run  = 1'b1;
    endtask

    task automatic stop_fx();
        fx_run = 1'b0;
        #(fx_off + 4 * fx_half + 20);
        clk_fx = 1'b0;
        @(negedge sys_clk);
    endtask

    // One measurement. align: start shortly after a clk_fx rise so ARM never
    // starves. Returns number of sampled busy cycles before done.
    task automatic do_measure(input int p, input bit align, input bit spam,
                              output int busy_cnt);
        exp_t e;
        int   d0;
        e = model(p);
        busy_cnt = 0;
        if (align) begin
            @(posedge clk_fx);
            @(negedge sys_clk);
            if (p <= 40) repeat ($urandom_range(0, p - 1)) @(negedge sys_clk);
        end
        exp_q.push_back(e);
        d0 = n_done;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("timeout_cleared", timeout, 0);
        #1;
        for (int i = 0; i < 600; i++) begin
            if (n_done != d0) break;
            if (busy) busy_cnt++;
            if (spam && busy && !done && (i % 7 == 3)) start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
            #1;
        end
        chk("done_seen", n_done - d0, 1);
        if (e.to == 0) chk("ratio", longint'(fx_count) * p, sys_count);
    endtask

    initial begin
        int bc;
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int p;

        // Reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_fx_count", fx_count, 0);
        chk("rst_sys_count", sys_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Basic measurement, 30-cycle period
        start_fx(30);
        do_measure(30, 1'b1, 1'b0, bc);
        stop_fx();

        // Edge coincides with gate end (period 50 closes exactly at the timeout limit)
        start_fx(50);
        do_measure(50, 1'b1, 1'b0, bc);
        stop_fx();

        // Period 100: closing edge lands 100 cycles after gate end, beyond T
        start_fx(100);
        do_measure(100, 1'b1, 1'b0, bc);
        stop_fx();

        // No signal: abort after T cycles in ARM
        do_measure(0, 1'b0, 1'b0, bc);
        chk("arm_timeout_cycles", bc, T);

        // Signal restored: timeout clears and result is correct
        start_fx(30);
        do_measure(30, 1'b1, 1'b0, bc);

        // Start pulses while busy are ignored
        do_measure(30, 1'b1, 1'b1, bc);

        // Reset in the middle of GATE
        @(posedge clk_fx);
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (60) @(negedge sys_clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_fx_count", fx_count, 0);
        chk("midrst_sys_count", sys_count, 0);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (200) @(negedge sys_clk);
        do_measure(30, 1'b1, 1'b0, bc);
        stop_fx();

        // Near-maximum frequency, random phase
        for (int k = 0; k < 4; k++) begin
            start_fx(3);
            do_measure(3, 1'b1, k[0], bc);
            total++;
            if (sys_count < 101 || sys_count > 103) begin
                bad++;
                $display("FAIL nearmax_range: got %0d expected 101..103", sys_count);
            end
            stop_fx();
        end

        // Random periods, each followed by a back-to-back restart
        for (int k = 0; k < 8; k++) begin
            p = $urandom_range(3, 40);
            start_fx(p);
            do_measure(p, 1'b1, k[0], bc);
            do_measure(p, 1'b0, 1'b0, bc);
            stop_fx();
        end

        repeat (20) @(negedge sys_clk);
        chk("pending_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
